// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle for 32 cycles, plus MTHI/MTLO.
// Define MDU_SIGNED_EN to make MULT/DIV signed; otherwise op[1] is ignored.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          isDiv_q, isDiv_d;
  logic [N-1:0]  operand_q, operand_d;
  logic [2*N-1:0] work_q, work_d;
  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d, divZero_q, divZero_d;

  logic [N-1:0]  aMag, bMag;
  logic [N:0]    mulSum;
  logic [2*N-1:0] mulNext;
  logic [2*N:0]  divShift;
  logic [2*N-1:0] divNext;
  logic [2*N-1:0] iterNext;
  logic [N-1:0]  resHi, resLo;
  logic          divByZero;

`ifdef MDU_SIGNED_EN
  logic aNeg, bNeg;
  logic negRes_q, negRes_d, negRem_q, negRem_d;

  assign aNeg = op[1] & inA[N-1];
  assign bNeg = op[1] & inB[N-1];
  assign aMag = aNeg ? -inA : inA;
  assign bMag = bNeg ? -inB : inB;
`else
  logic unusedOpSign;

  assign unusedOpSign = op[1];
  assign aMag = inA;
  assign bMag = inB;
`endif

  // The carry out of the add is shifted straight back in, so {carry, acc, mplier} fits in 2N bits.
  assign mulSum  = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, operand_q} : {(N+1){1'b0}});
  assign mulNext = {mulSum, work_q[N-1:1]};

  // A rem with bit N set after the shift always exceeds the divisor, so the trial wins.
  assign divShift = {work_q, 1'b0};
  assign divNext  = (divShift[2*N:N] >= {1'b0, operand_q})
                  ? {divShift[2*N-1:N] - operand_q, divShift[N-1:1], 1'b1}
                  : divShift[2*N-1:0];

  assign iterNext  = isDiv_q ? divNext : mulNext;
  assign divByZero = isDiv_q && (operand_q == '0);

  // Final-edge result, with sign correction when signed operation is built in.
  always_comb begin
    resHi = iterNext[2*N-1:N];
    resLo = iterNext[N-1:0];
`ifdef MDU_SIGNED_EN
    if (isDiv_q) begin
      if (!divByZero) begin
        resLo = negRes_q ? -iterNext[N-1:0]     : iterNext[N-1:0];
        resHi = negRem_q ? -iterNext[2*N-1:N]   : iterNext[2*N-1:N];
      end
    end else if (negRes_q) begin
      {resHi, resLo} = -iterNext;
    end
`endif
  end

  // Next-state: IDLE accepts start (which beats MTHI/MTLO); RUN iterates and retires on count N-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    operand_d = operand_q;
    work_d    = work_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = 1'b0;
`ifdef MDU_SIGNED_EN
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          isDiv_d = op[0];
          if (op[0]) begin
            operand_d = bMag;
            work_d    = {{N{1'b0}}, aMag};
          end else begin
            operand_d = aMag;
            work_d    = {{N{1'b0}}, bMag};
          end
`ifdef MDU_SIGNED_EN
          negRes_d = aNeg ^ bNeg;
          negRem_d = aNeg;
`endif
        end else begin
          if (hi_wen) hi_d = wd;
          if (lo_wen) lo_d = wd;
        end
      end
      RUN: begin
        work_d = iterNext;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d   = IDLE;
          hi_d      = resHi;
          lo_d      = resLo;
          done_d    = 1'b1;
          divZero_d = divByZero;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      operand_q <= '0;
      work_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
`ifdef MDU_SIGNED_EN
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      operand_q <= operand_d;
      work_q    <= work_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
`ifdef MDU_SIGNED_EN
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign div_zero = divZero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; signed cases are built when MDU_SIGNED_EN is defined.
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] inA;
  logic [N-1:0] inB;
  logic         hi_wen;
  logic         lo_wen;
  logic [N-1:0] wd;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int compareCount = 0;
  int failCount    = 0;

  mult_div_unit #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .inA      (inA),
    .inB      (inB),
    .hi_wen   (hi_wen),
    .lo_wen   (lo_wen),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic hw, input logic lw, input logic [N-1:0] d);
    start  = s;
    op     = o;
    inA    = a;
    inB    = b;
    hi_wen = hw;
    lo_wen = lw;
    wd     = d;
  endtask

  // Counts negedges while busy, starting at the current negedge; bounded.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clock);
    end
  endtask

  // Issues one operation; returns at the negedge after the final edge (done visible).
  task automatic runOp(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b, output int cycles);
    applyStimulus(1'b1, o, a, b, 1'b0, 1'b0, '0);
    @(negedge clock);
    applyStimulus(1'b0, o, a, b, 1'b0, 1'b0, '0);
    waitDone(cycles);
  endtask

  initial begin
    int cycles;
    logic sawDone;

    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("resetHi", hi, 32'h0);
    checkOutput("resetLo", lo, 32'h0);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetDivZero", div_zero, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // MULTU 0xFFFFFFFF x 2
    runOp(2'b00, 32'hFFFF_FFFF, 32'h2, cycles);
    checkOutput("multuBusyCycles", cycles, 32);
    checkOutput("multuDone", done, 1'b1);
    checkOutput("multuBusyAtDone", busy, 1'b0);
    checkOutput("multuHi", hi, 32'h0000_0001);
    checkOutput("multuLo", lo, 32'hFFFF_FFFE);
    checkOutput("multuDivZero", div_zero, 1'b0);
    @(negedge clock);
    checkOutput("multuDonePulse", done, 1'b0);

    // MTHI / MTLO in IDLE
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 32'h0000_1234);
    @(negedge clock);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("mthiHi", hi, 32'h0000_1234);
    checkOutput("mthiLoKept", lo, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 32'h0000_5678);
    @(negedge clock);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("mtloLo", lo, 32'h0000_5678);

    // DIVU 100/7 with a same-cycle MTHI (dropped), then MTLO and a second start while busy
    applyStimulus(1'b1, 2'b01, 32'd100, 32'd7, 1'b1, 1'b0, 32'h0000_BEEF);
    @(negedge clock);
    checkOutput("startWinsHi", hi, 32'h0000_1234);
    checkOutput("divuBusy", busy, 1'b1);
    applyStimulus(1'b1, 2'b00, 32'd9, 32'd9, 1'b0, 1'b1, 32'h0000_DEAD);
    @(negedge clock);
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("busyMtloIgnored", lo, 32'h0000_5678);
    checkOutput("runHiHeld", hi, 32'h0000_1234);
    waitDone(cycles);
    checkOutput("divuRemainingCycles", cycles, 31);
    checkOutput("divuDone", done, 1'b1);
    checkOutput("divuLo", lo, 32'd14);
    checkOutput("divuHi", hi, 32'd2);
    checkOutput("divuDivZero", div_zero, 1'b0);

    // DIVU 5/0 issued back-to-back in the done cycle
    runOp(2'b01, 32'd5, 32'd0, cycles);
    checkOutput("div0Cycles", cycles, 32);
    checkOutput("div0Done", done, 1'b1);
    checkOutput("div0Flag", div_zero, 1'b1);
    checkOutput("div0Lo", lo, 32'hFFFF_FFFF);
    checkOutput("div0Hi", hi, 32'd5);
    @(negedge clock);
    checkOutput("div0FlagPulse", div_zero, 1'b0);

    // Reset during iteration 10 of MULTU 3 x 4
    applyStimulus(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    @(negedge clock);
    applyStimulus(1'b0, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midResetHi", hi, 32'h0);
    checkOutput("midResetLo", lo, 32'h0);
    checkOutput("midResetBusy", busy, 1'b0);
    checkOutput("midResetDone", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterReset", sawDone, 1'b0);
    checkOutput("idleAfterReset", busy, 1'b0);
    runOp(2'b00, 32'd3, 32'd4, cycles);
    checkOutput("mul3x4Lo", lo, 32'd12);
    checkOutput("mul3x4Hi", hi, 32'd0);
    checkOutput("mul3x4Done", done, 1'b1);

    // DIVU is unsigned in either build
    runOp(2'b01, 32'hFFFF_FFF9, 32'd2, cycles);
    checkOutput("divuBigLo", lo, 32'h7FFF_FFFC);
    checkOutput("divuBigHi", hi, 32'h0000_0001);

`ifdef MDU_SIGNED_EN
    runOp(2'b10, 32'hFFFF_FFFD, 32'd5, cycles);
    checkOutput("multNegHi", hi, 32'hFFFF_FFFF);
    checkOutput("multNegLo", lo, 32'hFFFF_FFF1);
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2, cycles);
    checkOutput("divNegLo", lo, 32'hFFFF_FFFD);
    checkOutput("divNegHi", hi, 32'hFFFF_FFFF);
    runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
    checkOutput("divOvfLo", lo, 32'h8000_0000);
    checkOutput("divOvfHi", hi, 32'h0);
`else
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2, cycles);
    checkOutput("divAsDivuLo", lo, 32'h7FFF_FFFC);
    checkOutput("divAsDivuHi", hi, 32'h0000_0001);
    runOp(2'b10, 32'hFFFF_FFFF, 32'd2, cycles);
    checkOutput("multAsMultuHi", hi, 32'h0000_0001);
    checkOutput("multAsMultuLo", lo, 32'hFFFF_FFFE);
`endif

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle HI/LO multiply/divide unit in the EX stage, alongside the single-cycle ALU. Accepts MULT/MULTU/DIV/DIVU from the ID/EX operands and iterates one bit per cycle for 32 cycles. Holds the architectural HI and LO registers, including MTHI/MTLO writes. Drives `busy` so the hazard logic stalls any mult/div/MFHI/MFLO that issues while an operation is in flight.

## Interface
- `N`, 32, operand width; HI and LO are each `N` bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request, sampled on posedge.
- `op`  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `inA`, `inB`  in  N  rs and rt operands (multiplicand/dividend in `inA`, multiplier/divisor in `inB`).
- `hi_wen`, `lo_wen`  in  1  MTHI and MTLO write enables.
- `wd`  in  N  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  divisor was zero; valid with `done`.
- `hi`, `lo`  out  N  architectural HI and LO.

## Operation
- FSM states:
  - IDLE: `start` → RUN. Latch operands and `op`; iteration counter = 0.
  - RUN: one iteration per posedge. After the 32nd iteration, write HI and LO, then → IDLE.
- `busy` = (state == RUN), decoded combinationally.
- Multiply: shift-add on a 65-bit {carry, acc, multiplier} register.
  - If the multiplier LSB is 1, add the multiplicand to the upper 33 bits.
  - Then shift the whole register right by 1.
  - Result: HI = upper N bits, LO = lower N bits.
- Divide: restoring division on {rem, quot}.
  - Shift left by 1, then trial-subtract the divisor from rem.
  - If the trial result is non-negative, keep it and set the quotient LSB.
  - Result: LO = quotient, HI = remainder.
- Divide by zero: handled by the algorithm, no special case. Result is LO = all ones, HI = dividend; `div_zero` = 1 during the `done` cycle.
- MTHI/MTLO writes `wd` on posedge, only in IDLE with `start` = 0.
  - Ignored while busy.
  - If `start` is high in the same cycle, `start` wins and the write is dropped.
- `start` while busy: ignored; the current operation is unaffected.
- HI and LO hold their old values throughout RUN. They update only on the final edge.

## Timing
- Reset (async, `reset` = 0):
  - state = IDLE;
  - `busy` = 0, `done` = 0, `div_zero` = 0;
  - `hi` = 0, `lo` = 0;
  - counter and datapath registers cleared.
- Reset mid-operation: the operation is abandoned and produces no `done`.
- Let edge k be the edge that samples `start` in IDLE:
  - `busy` = 1 from after edge k through edge k+32;
  - HI and LO are written at edge k+32;
  - `done` (and `div_zero`) are high for exactly the cycle after edge k+32;
  - `busy` = 0 in that same cycle.
- Back-to-back operation: `start` sampled at edge k+33 is accepted and runs normally.
- Latency: 32 cycles from start sample to result. Throughput: one operation per 33 cycles.

## Configuration
- `MDU_SIGNED_EN` defined: MULT and DIV are signed.
  - Operands are converted to magnitudes at start; signs are fixed on the final edge.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - Divide by zero uses the magnitude result, with no sign fix.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- `MDU_SIGNED_EN` undefined: `op[1]` is ignored. MULT behaves as MULTU and DIV as DIVU; no sign logic is synthesized.

## Test plan
- MULTU 0xFFFFFFFF × 2:
  - HI = 0x00000001, LO = 0xFFFFFFFE;
  - `done` in the cycle after edge k+32;
  - `busy` high for exactly 32 cycles.
- DIVU 100 / 7 → LO = 14, HI = 2, `div_zero` = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5, `div_zero` = 1 with `done`.
- MTHI 0x1234 in IDLE → `hi` = 0x1234 after the edge.
  - MTLO asserted while busy → `lo` unchanged.
  - Second `start` while busy → ignored, first result intact.
- Reset during iteration 10 of MULTU 3 × 4:
  - `hi` = `lo` = 0, `busy` = 0, no `done`;
  - a subsequent MULTU 3 × 4 gives LO = 12, HI = 0.
- With `MDU_SIGNED_EN`:
  - MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Without the macro, DIV 0xFFFFFFF9 / 2 → LO = 0x7FFFFFFC, HI = 1.
